// File: rtl/rca_writeback_unit.sv
// rca_writeback_unit: drains the running RCA's result lane into a small circular
// buffer and presents in-order completions to the Taiga writeback port.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   currently_running_rca        selects the grid result lane to drain
//   grid_result_valid/data/pop   per-RCA output FIFO head and pop strobes
//   clear_fifos                  flush request (accelerator switch)
//   fifo_populated, wb_id,
//   wb_fb_instr                  issue controller ID FIFO head
//   wb_done, wb_rd, wb_id_out,
//   wb_ack                       writeback completion handshake
//   wb_committing                one-cycle pop strobe to the controller ID FIFO
//   protocol_err                 sticky flag: flush seen while a completion was in flight
module rca_writeback_unit #(
  parameter int XLEN             = 32,
  parameter int NUM_RCAS         = 4,
  parameter int RESULT_BUF_DEPTH = 4,
  parameter int ID_W             = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_RCAS)-1:0]   currently_running_rca,
  input  logic                          clear_fifos,
  input  logic                          fifo_populated,
  input  logic [ID_W-1:0]               wb_id,
  input  logic                          wb_fb_instr,
  input  logic [NUM_RCAS-1:0]           grid_result_valid,
  input  logic [NUM_RCAS*XLEN-1:0]      grid_result_data,
  output logic [NUM_RCAS-1:0]           grid_result_pop,
  output logic                          wb_done,
  output logic [XLEN-1:0]               wb_rd,
  output logic [ID_W-1:0]               wb_id_out,
  input  logic                          wb_ack,
  output logic                          wb_committing,
  output logic                          protocol_err
);
  localparam int PW = $clog2(RESULT_BUF_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RESULT_BUF_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_RESULT, PRESENT} state_t;
  state_t          r_state, w_next;
  logic [XLEN-1:0] r_buf [RESULT_BUF_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;
  logic            r_wb_done, r_err;
  logic [XLEN-1:0] r_wb_rd;
  logic [ID_W-1:0] r_wb_id;
  logic            w_push, w_take, w_latch, w_fb, w_has_data;
  logic [XLEN-1:0] w_data;
  // Pop is held off during reset so the grid never loses a result while we are cleared.
  assign w_push          = rst && grid_result_valid[currently_running_rca] && (r_count < FULL) && !clear_fifos;
  assign w_data          = grid_result_data[currently_running_rca*XLEN +: XLEN];
  assign grid_result_pop = NUM_RCAS'(w_push) << currently_running_rca;
  // A flush in the same cycle discards the head, so the FSM must not consume it.
  assign w_has_data      = (r_count != '0) && !clear_fifos;
  assign wb_done         = r_wb_done;
  assign wb_rd           = r_wb_rd;
  assign wb_id_out       = r_wb_id;
  assign wb_committing   = r_wb_done && wb_ack;
  assign protocol_err    = r_err;
  always_comb begin
    w_next  = r_state;
    w_take  = 1'b0;
    w_latch = 1'b0;
    w_fb    = 1'b0;
    case (r_state)
      IDLE: begin
        if (fifo_populated && wb_fb_instr) begin
          w_latch = 1'b1;
          w_fb    = 1'b1;
          w_next  = PRESENT;
        end else if (fifo_populated && w_has_data) begin
          w_latch = 1'b1;
          w_take  = 1'b1;
          w_next  = PRESENT;
        end else if (fifo_populated) begin
          w_next = WAIT_RESULT;
        end
      end
      WAIT_RESULT: begin
        if (w_has_data) begin
          w_latch = 1'b1;
          w_take  = 1'b1;
          w_next  = PRESENT;
        end
      end
      PRESENT: w_next = wb_ack ? IDLE : PRESENT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_wb_done <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_id   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wb_done <= (w_next == PRESENT);
      r_err     <= r_err | (clear_fifos && (r_state != IDLE));
      if (clear_fifos) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_take) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_take);
      end
      if (w_latch) begin
        r_wb_id <= wb_id;
        r_wb_rd <= w_fb ? '0 : r_buf[r_rd_ptr];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= w_data;
  end
endmodule

// File: tb/tb_rca_writeback_unit.sv
// tb_rca_writeback_unit: scoreboard bench for rca_writeback_unit with directed vectors.
module tb_rca_writeback_unit;
  localparam int XL = 32;
  localparam int NR = 4;
  localparam int IW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] sel;
  logic clear, fpop, fb, wb_ack;
  logic [IW-1:0] wb_id, wb_id_out;
  logic [NR-1:0] gvalid, pop;
  logic [NR*XL-1:0] gdata;
  logic wb_done, commit, perr;
  logic [XL-1:0] wb_rd;
  logic [IW+XL-1:0] sb [$];
  logic [IW+XL-1:0] e;
  logic prev_commit = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int bp_v, npop, head;
  logic ack_en;
  rca_writeback_unit #(.XLEN(XL), .NUM_RCAS(NR), .RESULT_BUF_DEPTH(4), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .currently_running_rca(sel), .clear_fifos(clear),
    .fifo_populated(fpop), .wb_id(wb_id), .wb_fb_instr(fb),
    .grid_result_valid(gvalid), .grid_result_data(gdata), .grid_result_pop(pop),
    .wb_done(wb_done), .wb_rd(wb_rd), .wb_id_out(wb_id_out), .wb_ack(wb_ack),
    .wb_committing(commit), .protocol_err(perr)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done(string nm);
    for (int t = 0; t < 20 && !wb_done; t++) step();
    chk(nm, 64'(wb_done), 64'd1);
  endtask
  task automatic ack_one();
    wb_ack = 1'b1;
    @(negedge clk);
    step();
    wb_ack = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rst && commit) begin
      chk("commit_single_cycle", 64'(prev_commit), 64'd0);
      if (sb.size() == 0) chk("unexpected_completion", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e[XL-1:0]));
        chk("wb_id_out", 64'(wb_id_out), 64'(e[IW+XL-1:XL]));
      end
    end
    prev_commit <= commit;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    sel = 0; clear = 0; fpop = 0; fb = 0; wb_ack = 0; wb_id = 0; gvalid = 4'b0001; gdata = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_wb_done", 64'(wb_done), 0);
    chk("rst_pop", 64'(pop), 0);
    chk("rst_wb_rd", 64'(wb_rd), 0);
    chk("rst_wb_id", 64'(wb_id_out), 0);
    chk("rst_err", 64'(perr), 0);
    chk("rst_commit", 64'(commit), 0);
    step();
    gvalid = 0;
    rst = 1;
    // single result on lane 2
    sel = 2; fpop = 1; wb_id = 5; gvalid = 4'b0100; gdata[2*XL +: XL] = 32'hDEADBEEF;
    sb.push_back({4'd5, 32'hDEADBEEF});
    @(negedge clk); chk("A_pop", 64'(pop), 64'h4);
    step(); gvalid = 0;
    @(negedge clk); chk("A_pop_once", 64'(pop), 0); chk("A_done_early", 64'(wb_done), 0);
    step();
    @(negedge clk); chk("A_done", 64'(wb_done), 1);
    step(); wb_ack = 1;
    @(negedge clk); chk("A_commit", 64'(commit), 1);
    step(); wb_ack = 0; fpop = 0;
    @(negedge clk); chk("A_commit_drop", 64'(commit), 0); chk("A_done_drop", 64'(wb_done), 0);
    // feedback instruction
    step(); fpop = 1; wb_id = 7; fb = 1;
    sb.push_back({4'd7, 32'h0});
    @(negedge clk); chk("B_done_early", 64'(wb_done), 0);
    step();
    @(negedge clk); chk("B_done", 64'(wb_done), 1); chk("B_no_pop", 64'(pop), 0);
    step(); ack_one();
    fpop = 0; fb = 0;
    // back-pressure on lane 0, values 1..6, then drain with immediate acks
    sel = 0; bp_v = 1; npop = 0; head = 1; ack_en = 0;
    for (int v = 1; v <= 6; v++) sb.push_back({IW'(v), XL'(v)});
    for (int c = 0; c < 80 && head <= 6; c++) begin
      step();
      gdata[XL-1:0] = XL'(bp_v); gvalid[0] = (bp_v <= 6); wb_id = IW'(head); fpop = 1;
      wb_ack = ack_en && wb_done;
      @(negedge clk);
      if (pop[0]) begin bp_v++; npop++; end
      if (commit) head++;
      if (c == 11) begin
        chk("C_pops_at_full", 64'(npop), 5);
        chk("C_stall", 64'(pop), 0);
        ack_en = 1;
      end
    end
    chk("C_all_done", 64'(head), 7);
    chk("C_total_pops", 64'(npop), 6);
    step(); wb_ack = 0; fpop = 0; gvalid = 0;
    // clear with concurrent push, first in IDLE then in WAIT_RESULT
    sel = 1; gvalid = 4'b0010;
    for (int i = 0; i < 3; i++) begin gdata[XL +: XL] = XL'(32'h100 + i); step(); end
    clear = 1;
    @(negedge clk); chk("D_clear_nopop", 64'(pop), 0);
    step(); clear = 0; gvalid = 0; fpop = 1; wb_id = 3;
    @(negedge clk); chk("D_err_idle", 64'(perr), 0);
    step(); step();
    @(negedge clk); chk("D_flushed", 64'(wb_done), 0);
    step(); wb_ack = 1;
    @(negedge clk); chk("D_ack_ignored", 64'(commit), 0);
    step(); wb_ack = 0; clear = 1;
    step(); clear = 0;
    @(negedge clk); chk("D_err_set", 64'(perr), 1);
    step(); gvalid = 4'b0010; gdata[XL +: XL] = 32'hA5A50003;
    sb.push_back({4'd3, 32'hA5A50003});
    step(); gvalid = 0;
    wait_done("D_done");
    ack_one();
    fpop = 0;
    @(negedge clk); chk("D_err_sticky", 64'(perr), 1);
    // lane isolation
    step(); sel = 1; fpop = 1; wb_id = 4; gvalid = 4'b1000; gdata[3*XL +: XL] = 32'h33333333;
    @(negedge clk); chk("E_no_pop", 64'(pop), 0);
    step(); step();
    @(negedge clk); chk("E_no_pop2", 64'(pop), 0); chk("E_no_done", 64'(wb_done), 0);
    step(); sel = 3;
    sb.push_back({4'd4, 32'h33333333});
    @(negedge clk); chk("E_pop3", 64'(pop), 64'h8);
    step(); gvalid = 0;
    wait_done("E_done");
    ack_one();
    fpop = 0;
    // reset while presenting with two entries buffered
    step(); sel = 0; fpop = 1; wb_id = 2; gvalid = 4'b0001;
    for (int i = 0; i < 3; i++) begin gdata[XL-1:0] = XL'(32'h10 + i); step(); end
    gvalid = 0;
    @(negedge clk); chk("F_in_present", 64'(wb_done), 1);
    step(); gvalid = 4'b0001; rst = 0;
    #1;
    chk("F_rst_done", 64'(wb_done), 0);
    chk("F_rst_pop", 64'(pop), 0);
    chk("F_rst_err", 64'(perr), 0);
    chk("F_rst_commit", 64'(commit), 0);
    step(); gvalid = 0; rst = 1; fpop = 1; wb_id = 6;
    step(); step();
    @(negedge clk); chk("F_count_cleared", 64'(wb_done), 0);
    step(); fpop = 0;
    step();
    chk("sb_drained", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/rca_writeback_unit.md
Name: rca_writeback_unit

Overview:
- Sits directly downstream of the RCA grid and the grid issue controller. Consumes in-order instruction IDs and the feedback flag from the controller's ID FIFO head.
- Drains results from the output FIFO of the currently running RCA into a local result buffer. Presents one completion at a time to the Taiga writeback interface.
- Pulses wb_committing back to the controller so it pops its ID FIFO.

Parameters:
- XLEN, 32, result data width
- NUM_RCAS, 4, number of accelerators (≥2)
- RESULT_BUF_DEPTH, 4, local result buffer entries (power of 2, ≥2)
- ID_W, $bits(id_t), instruction ID width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- currently_running_rca  in  $clog2(NUM_RCAS)  selects the grid result lane to drain
- clear_fifos  in  1  flush request from the controller (accelerator switch)
- fifo_populated  in  1  controller ID FIFO non-empty
- wb_id  in  ID_W  controller ID FIFO head
- wb_fb_instr  in  1  head instruction is a feedback-use instruction
- grid_result_valid  in  NUM_RCAS  per-RCA output FIFO non-empty
- grid_result_data  in  NUM_RCAS×XLEN  per-RCA output FIFO head data
- grid_result_pop  out  NUM_RCAS  per-RCA pop strobe
- wb_done  out  1  completion valid to the Taiga writeback
- wb_rd  out  XLEN  completion result
- wb_id_out  out  ID_W  completion ID
- wb_ack  in  1  writeback accepts the completion
- wb_committing  out  1  one-cycle pop strobe to the controller ID FIFO
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE and the buffer count goes to 0.
  - wb_done=0, wb_rd=0, wb_id_out=0, protocol_err=0.
  - grid_result_pop=0 and wb_committing=0 (both combinational from reset state).
- Result capture, combinational pop and registered push:
  - Let s = currently_running_rca.
  - grid_result_pop[s] = grid_result_valid[s] && (count < RESULT_BUF_DEPTH) && !clear_fifos. All other pop bits are 0.
  - When pop[s]=1, grid_result_data[s] is written at the tail on that clock edge.
  - Valid on non-selected lanes is ignored.
- Buffer:
  - Circular, with rd/wr pointers wrapping modulo RESULT_BUF_DEPTH.
  - count updates by +push −pop; simultaneous push and pop leaves count unchanged.
  - When full, no pop is issued to the grid (back-pressure). The buffer never overflows.
- clear_fifos: on the next edge, count=0 and both pointers=0. It overrides any push or internal pop in the same cycle.
- FSM:
  - IDLE:
    - If fifo_populated && wb_fb_instr: latch wb_id_out=wb_id and wb_rd=0, then go to PRESENT. Feedback instructions write no result and consume no buffer entry.
    - Else if fifo_populated && count≠0: latch wb_id_out=wb_id and wb_rd=buffer head, pop the buffer, then go to PRESENT.
    - Else if fifo_populated: go to WAIT_RESULT.
    - Otherwise stay in IDLE.
  - WAIT_RESULT: when count≠0, latch the ID and head, pop the buffer, and go to PRESENT.
  - PRESENT:
    - wb_done=1 (registered, asserted throughout the state).
    - wb_rd and wb_id_out are held stable until acknowledged.
    - When wb_ack=1: wb_committing=wb_done&&wb_ack (combinational, exactly 1 cycle), wb_done deasserts on the next edge, and the FSM goes to IDLE.
- Latency:
  - Result pushed at edge N, FSM in IDLE with ID present → wb_done=1 after edge N+1.
  - Ack at cycle M → next completion may assert wb_done no earlier than after edge M+2, because the controller pops at M and the new head is sampled in IDLE at M+1.
- Boundary conditions:
  - A buffer non-empty with fifo_populated=0 holds its data; it is not an error.
  - clear_fifos while the FSM is not IDLE sets protocol_err=1 (sticky until reset). The FSM continues normally.
  - wb_ack outside PRESENT is ignored.
  - Reset mid-PRESENT drops the completion. The controller is reset concurrently.
  - A change of currently_running_rca redirects capture from the next cycle onward.

Test Plan:
- Reset mid-operation: assert rst=0 in PRESENT with count=2 → wb_done=0, grid_result_pop=0, count=0, protocol_err=0 immediately.
- Single result: fifo_populated=1, wb_id=5, wb_fb_instr=0; lane 2 selected, valid with 0xDEADBEEF → pop[2]=1 for one cycle; wb_done=1 with wb_rd=0xDEADBEEF and wb_id_out=5 two edges later; wb_ack=1 → wb_committing=1 that cycle only.
- Feedback instruction: fifo_populated=1, wb_fb_instr=1, no grid results → wb_done=1 with wb_rd=0 one edge later; buffer count stays 0.
- Back-pressure: DEPTH=4, wb_ack held 0, lane 0 valid continuously with data 1,2,3,4,5,6 → exactly 5 pops (4 buffered plus 1 taken into PRESENT); pop[0]=0 thereafter. Releasing ack delivers values 1..6 in order with the wrap-around verified.
- Clear with concurrent push: count=3, clear_fifos=1 with lane valid → no pop that cycle, count=0 next cycle, protocol_err=0 in IDLE. Repeat while in WAIT_RESULT → protocol_err=1, which persists.
- Lane isolation: currently_running_rca=1, only grid_result_valid[3]=1 → no pops and wb_done stays 0; switch to 3 → pop[3]=1 on the next cycle.
